// File: rtl/riscv_pkg.sv
// Shared RISC-V core package.
//   - ALU opcode encodings (ALU_ADD .. ALU_SLT), shared with the ALU itself.
//   - alu_class encodings supplied by the main decoder.
//   - alu_decode(): maps class/funct3/funct7b5 to a 4-bit ALU opcode.
//   - is_shift_op(): true for sll/srl/sra, whose B operand uses only bits [4:0].
package riscv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALU_CLASS_ADD = 2'b00;  // ld / sd address
  localparam logic [1:0] ALU_CLASS_SUB = 2'b01;  // branch compare
  localparam logic [1:0] ALU_CLASS_R   = 2'b10;  // R-type
  localparam logic [1:0] ALU_CLASS_I   = 2'b11;  // I-type arithmetic

  function automatic logic [3:0] alu_decode(input logic [1:0] alu_class,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5);
    logic [3:0] op;
    op = ALU_ADD;
    case (alu_class)
      ALU_CLASS_ADD: op = ALU_ADD;
      ALU_CLASS_SUB: op = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  op = (alu_class == ALU_CLASS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          // srai/srli share funct3; bit 30 selects arithmetic for both R and I forms.
          3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
    endcase
    return op;
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding mux for one source register.
//   rs            : source register address held in ID/EX
//   reg_data      : register-file value captured in ID/EX
//   exm_*         : EX/MEM forward source (highest priority)
//   mwb_*         : MEM/WB forward source
//   fwd_data      : selected operand value
// Build option ID_EX_FORWARD_EN: when undefined the forward sources are
// ignored and fwd_data is always reg_data.
module forward_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic            mwb_reg_write,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] fwd_data
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic exm_hit;
  logic mwb_hit;

  // x0 is never a forwarding source: its writes are discarded.
  assign exm_hit = FWD_EN && exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
  assign mwb_hit = FWD_EN && mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

  always_comb begin
    fwd_data = reg_data;
    if (exm_hit) begin
      fwd_data = exm_result;  // younger result wins
    end else if (mwb_hit) begin
      fwd_data = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage, directly upstream of the ALU.
// Registers decoded operands/control, decodes the ALU opcode at load time,
// forwards EX/MEM and MEM/WB results onto alu_ina/alu_inb/ex_store_data and
// detects load-use hazards.
// Ports:
//   clk, reset (async, active-high)
//   id_*            : instruction from decode
//   flush           : branch redirect, kills the instruction entering the stage
//   exm_*, mwb_*    : forward sources
//   hazard_stall    : hold PC and IF/ID this cycle (combinational)
//   ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write : registered control
//   alu_op          : registered ALU opcode
//   alu_ina, alu_inb, ex_store_data : combinational operands
// Build option ID_EX_FORWARD_EN enables forwarding (see forward_mux).
//
// Handshake: decode presents an instruction with id_valid; it is taken on a
// rising edge when flush and hazard_stall are both low. While hazard_stall is
// high decode must hold its instruction unchanged; this stage loads a bubble.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [1:0]      id_alu_class,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            flush,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic            mwb_reg_write,
  input  logic [XLEN-1:0] mwb_result,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_ina,
  output logic [XLEN-1:0] alu_inb,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write
);

  logic            ex_alu_src;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] inb_raw;
  logic            load_bubble;

  // A load in EX whose destination is read by the decode instruction cannot
  // be forwarded in time. Depends only on registered state and id_*, so
  // async reset clears it immediately. The bubble it inserts drops
  // ex_mem_read, so each stall lasts exactly one cycle.
  assign hazard_stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign load_bubble = flush || hazard_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_rd        <= '0;
      alu_op       <= ALU_ADD;
      ex_alu_src   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
    end else if (load_bubble) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_rd        <= '0;
      alu_op       <= ALU_ADD;
      ex_alu_src   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_reg_write <= id_reg_write;
      ex_rd        <= id_rd;
      alu_op       <= alu_decode(id_alu_class, id_funct3, id_funct7b5);
      ex_alu_src   <= id_alu_src;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
    end
  end

  forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs            (ex_rs1),
    .reg_data      (ex_rs1_data),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rs1)
  );

  forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs            (ex_rs2),
    .reg_data      (ex_rs2_data),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .fwd_data      (fwd_rs2)
  );

  assign alu_ina       = fwd_rs1;
  assign ex_store_data = fwd_rs2;
  assign inb_raw       = ex_alu_src ? ex_imm : fwd_rs2;

  // Shift amounts use only bits [4:0]; this strips funct7 from srai/srli/slli.
  always_comb begin
    alu_inb = inb_raw;
    if (is_shift_op(alu_op)) begin
      alu_inb = {{(XLEN-5){1'b0}}, inb_raw[4:0]};
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int W = 110;

  typedef struct {
    logic        id_valid;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7, src, mr, mw, rw, flush;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  mwb_rd;
    logic        mwb_rw;
    logic [31:0] mwb_res;
  } stim_t;

  // Reference view of the instruction currently sitting in EX.
  typedef struct {
    logic        valid, mr, mw, rw, src;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] d1, d2, imm;
  } slot_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid, id_funct7b5, id_alu_src, id_mem_read, id_mem_write, id_reg_write, flush;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exm_result, mwb_result;
  logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, mwb_rd;
  logic [1:0]  id_alu_class;
  logic [2:0]  id_funct3;
  logic        exm_reg_write, mwb_reg_write;
  logic        hazard_stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [3:0]  alu_op;
  logic [31:0] alu_ina, alu_inb, ex_store_data;
  logic [4:0]  ex_rd;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_class(id_alu_class), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  slot_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [3:0] ref_op(input logic [1:0] cls, input logic [2:0] f3, input logic f7);
    logic [3:0] tab[8];
    logic [3:0] op;
    if (cls == 2'b00) return 4'b0010;
    if (cls == 2'b01) return 4'b0110;
    // add sll slt sltu xor srl or and
    tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0111, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    op = tab[f3];
    if (f3 == 3'd0 && cls == 2'b10 && f7) op = 4'b0110;
    if (f3 == 3'd5 && f7) op = 4'b1001;
    return op;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] d, input stim_t s);
`ifdef ID_EX_FORWARD_EN
    if (s.exm_rw && s.exm_rd != 5'd0 && s.exm_rd == rs) return s.exm_res;
    if (s.mwb_rw && s.mwb_rd != 5'd0 && s.mwb_rd == rs) return s.mwb_res;
`endif
    return d;
  endfunction

  function automatic slot_t empty_slot();
    slot_t e;
    e = '{valid: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, src: 1'b0, rd: 5'd0, rs1: 5'd0,
          rs2: 5'd0, op: 4'b0010, d1: 32'd0, d2: 32'd0, imm: 32'd0};
    return e;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{id_valid: 1'b0, d1: 32'd0, d2: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          cls: 2'b00, f3: 3'd0, f7: 1'b0, src: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, flush: 1'b0,
          exm_rd: 5'd0, exm_rw: 1'b0, exm_res: 32'd0, mwb_rd: 5'd0, mwb_rw: 1'b0, mwb_res: 32'd0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_valid = ($urandom_range(0, 7) != 0);
    s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3)); s.rd = 5'($urandom_range(0, 3));
    s.cls = 2'($urandom_range(0, 3)); s.f3 = 3'($urandom_range(0, 7)); s.f7 = 1'($urandom_range(0, 1));
    s.src = 1'($urandom_range(0, 1)); s.mr = ($urandom_range(0, 2) == 0);
    s.mw = 1'($urandom_range(0, 1)); s.rw = 1'($urandom_range(0, 1));
    s.flush = ($urandom_range(0, 9) == 0);
    s.exm_rd = 5'($urandom_range(0, 3)); s.exm_rw = 1'($urandom_range(0, 1)); s.exm_res = $urandom;
    s.mwb_rd = 5'($urandom_range(0, 3)); s.mwb_rw = 1'($urandom_range(0, 1)); s.mwb_res = $urandom;
    return s;
  endfunction

  // driver: one clock cycle of stimulus. rst_mode 0 = none, 1 = reset this
  // cycle, 2 = reset only if a stall is predicted this cycle.
  task automatic do_cycle(input stim_t s, input int rst_mode);
    logic        exp_stall;
    logic        rst;
    logic [31:0] a, b, bi;
    @(negedge clk);
    id_valid = s.id_valid; id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_alu_class = s.cls;
    id_funct3 = s.f3; id_funct7b5 = s.f7; id_alu_src = s.src;
    id_mem_read = s.mr; id_mem_write = s.mw; id_reg_write = s.rw; flush = s.flush;
    exm_rd = s.exm_rd; exm_reg_write = s.exm_rw; exm_result = s.exm_res;
    mwb_rd = s.mwb_rd; mwb_reg_write = s.mwb_rw; mwb_result = s.mwb_res;
    #1;
    exp_stall = m.valid && m.mr && m.rd != 5'd0 && s.id_valid && (m.rd == s.rs1 || m.rd == s.rs2);
    rst = (rst_mode == 1) || (rst_mode == 2 && exp_stall);
    if (rst) begin
      reset = 1'b1;
      m = empty_slot();
      exp_stall = 1'b0;
    end
    a = ref_fwd(m.rs1, m.d1, s);
    b = ref_fwd(m.rs2, m.d2, s);
    bi = m.src ? m.imm : b;
    if (m.op == 4'b0100 || m.op == 4'b0101 || m.op == 4'b1001) bi = bi & 32'h1f;
    exp_q.push_back({exp_stall, m.valid, m.rd, m.mr, m.mw, m.rw, m.op, a, bi, b});
    #2 reset = 1'b0;
    @(posedge clk);
    if (s.flush || exp_stall) begin
      m = empty_slot();
    end else begin
      m.valid = s.id_valid; m.mr = s.mr; m.mw = s.mw; m.rw = s.rw; m.src = s.src;
      m.rd = s.rd; m.rs1 = s.rs1; m.rs2 = s.rs2; m.op = ref_op(s.cls, s.f3, s.f7);
      m.d1 = s.d1; m.d2 = s.d2; m.imm = s.imm;
    end
  endtask

  // monitor: compares what the DUT presents every cycle against the queue
  always begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = {hazard_stall, ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write,
             alu_op, alu_ina, alu_inb, ex_store_data};
      check("hazard_stall", 32'(act[109]), 32'(e[109]));
      check("ctrl{valid,rd,mr,mw,rw}", 32'(act[108:100]), 32'(e[108:100]));
      check("alu_op", 32'(act[99:96]), 32'(e[99:96]));
      check("alu_ina", act[95:64], e[95:64]);
      check("alu_inb", act[63:32], e[63:32]);
      check("ex_store_data", act[31:0], e[31:0]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    m = empty_slot();
    do_cycle(idle_stim(), 1);

    // R-type sub: x5=10, x6=3
    s = idle_stim();
    s.id_valid = 1; s.rs1 = 5; s.d1 = 10; s.rs2 = 6; s.d2 = 3; s.rd = 7;
    s.cls = 2'b10; s.f3 = 0; s.f7 = 1; s.rw = 1;
    do_cycle(s, 0);
    // same instruction again while both forward sources target x5
    s.exm_rd = 5; s.exm_rw = 1; s.exm_res = 7; s.mwb_rd = 5; s.mwb_rw = 1; s.mwb_res = 9;
    do_cycle(s, 0);
    s.exm_rd = 0;
    do_cycle(s, 0);
    s.exm_rd = 5;
    do_cycle(s, 0);

    // load-use: ld x5, then add using x5 held by decode across the stall
    s = idle_stim();
    s.id_valid = 1; s.rd = 5; s.rs1 = 2; s.mr = 1; s.rw = 1; s.src = 1; s.imm = 8;
    do_cycle(s, 0);
    s = idle_stim();
    s.id_valid = 1; s.rs1 = 5; s.rs2 = 3; s.d1 = 32'h11; s.d2 = 32'h22; s.rd = 9; s.cls = 2'b10; s.rw = 1;
    do_cycle(s, 0);
    do_cycle(s, 0);
    do_cycle(idle_stim(), 0);

    // flush with a valid decode instruction
    s.flush = 1;
    do_cycle(s, 0);
    do_cycle(idle_stim(), 0);

    // srai x?, imm 0x40000403
    s = idle_stim();
    s.id_valid = 1; s.cls = 2'b11; s.f3 = 3'd5; s.f7 = 1; s.src = 1; s.imm = 32'h40000403; s.rw = 1; s.rd = 4;
    do_cycle(s, 0);
    do_cycle(idle_stim(), 0);

    // reset while a stall is being raised
    s = idle_stim();
    s.id_valid = 1; s.rd = 3; s.mr = 1; s.rw = 1;
    do_cycle(s, 0);
    s = idle_stim();
    s.id_valid = 1; s.rs2 = 3; s.cls = 2'b10;
    do_cycle(s, 1);
    do_cycle(s, 0);

    // randomized stream with occasional reset during a stall
    for (int i = 0; i < 400; i++) begin
      do_cycle(rand_stim(), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end
    do_cycle(idle_stim(), 0);

    repeat (2) @(negedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
